hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage RV32I pipeline.
- Keeps its own shadow copy of destination-register info for the EX, ME and WB stages.
- Drives the forwarding selects feeding mux_a/mux_b of the execute stage.
- Generates fetch/decode stalls for load-use hazards and decode/execute clears for taken branches signalled by the BU.

Parameters:
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..3).
- XLEN_REGS, 5, register index width.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  synchronous active-low reset
- rs1_de  input  5  decode-stage source 1 index
- rs2_de  input  5  decode-stage source 2 index
- rd_de  input  5  decode-stage destination index
- RUwrite_de  input  1  decode-stage register write enable
- is_load_de  input  1  decode-stage instruction is a load (RU_DM_write_src == 2'b01)
- rs1_ex  input  5  execute-stage source 1 index
- rs2_ex  input  5  execute-stage source 2 index
- next_pc_src_ex  input  1  taken branch/jump from BU this cycle
- fwd_a_sel  output  2  mux_a select: 00 register file, 01 ALU_res_me, 10 WB write data
- fwd_b_sel  output  2  mux_b select, same encoding
- stall_fe  output  1  hold PC
- stall_de  output  1  hold FE/DE register
- clr_de  output  1  bubble FE/DE register
- clr_ex  output  1  bubble DE/EX control fields
- busy  output  1  FSM not in RUN

Behaviour:
- Reset (rst_n low at posedge):
  - FSM enters RUN; stall counter = 0.
  - All shadow stage registers (rd, wr, load for EX/ME/WB) cleared to 0.
  - Outputs read 0: fwd_a_sel and fwd_b_sel = 00; stall_fe, stall_de, clr_de, clr_ex, busy = 0.
- Shadow pipeline, every posedge:
  - WB <= ME; ME <= EX.
  - EX <= decode fields {rd_de, RUwrite_de, is_load_de}.
  - Exception: EX <= 0 (bubble) when clr_ex is asserted that cycle.
- Forwarding (combinational from shadow state and rs*_ex):
  - ME match (ME.wr, ME.rd != 0, ME.rd == rs) -> 01.
  - Else WB match -> 10.
  - Else 00.
  - ME has priority over WB. rs == x0 always yields 00.
  - ME load with match: select 01 is never produced, because the load-use stall guarantees separation.
- Load-use detect (combinational):
  - luh = EX.load & EX.wr & EX.rd != 0 & (EX.rd == rs1_de | EX.rd == rs2_de).
- FSM states RUN, LSTALL, FLUSH:
  - RUN:
    - next_pc_src_ex -> FLUSH outputs this cycle (clr_de = 1, clr_ex = 1); stay RUN. The branch overrides luh.
    - Else luh -> stall_fe = stall_de = 1, clr_ex = 1; counter <= LOAD_LAT-1. Go to LSTALL if LOAD_LAT > 1, else stay RUN.
  - LSTALL:
    - stall_fe = stall_de = clr_ex = 1; busy = 1.
    - Counter decrements each cycle; return to RUN when counter == 0 at posedge.
    - If next_pc_src_ex asserts in LSTALL: abort the stall, assert clr_de/clr_ex, go to FLUSH for one cycle.
  - FLUSH:
    - clr_de = clr_ex = 1, stall_* = 0, busy = 1.
    - Next state RUN unconditionally.
- Simultaneous clr and stall: clr wins for the FE/DE register.
  - When clr_de = 1, stall_de is forced 0 so the bubble is written.
- Reset mid-stall or mid-flush: state, counter and shadow registers clear on the same edge; no residual stall.
- Latency:
  - Forwarding and detection are zero-cycle combinational.
  - Stall/flush outputs are combinational from present state plus inputs.
  - No output depends combinationally on fwd_*_sel.

Optional Feature:
- HAZARD_PERF_EN: when defined, adds three 32-bit outputs, all cleared by reset:
  - stall_cnt: increments on each cycle with stall_fe = 1.
  - flush_cnt: increments on each cycle with clr_de = 1.
  - fwd_cnt: increments on each cycle where either select != 00.
- Counters saturate at 32'hFFFF_FFFF.
- When not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- add x5 then sub using rs1 = x5 next cycle -> in EX of sub, fwd_a_sel = 01. One cycle later, an instruction reading x5 gets fwd_*_sel = 10.
- lw x6 followed by add rs2 = x6, LOAD_LAT = 1 -> exactly one cycle with stall_fe = stall_de = clr_ex = 1; then fwd_b_sel = 10 for the add.
- LOAD_LAT = 3, same sequence -> stall asserted 3 consecutive cycles, busy = 1 for 2; next_pc_src_ex pulsed in cycle 2 -> stall drops, clr_de = clr_ex = 1 for 2 cycles, then RUN.
- Branch taken (next_pc_src_ex = 1) while luh = 1 -> clr_de = clr_ex = 1, stall_fe = stall_de = 0.
- Write to x0 with matching rs = 0 -> fwd_*_sel stay 00, no stall even for lw x0.
- rst_n = 0 during LSTALL -> next cycle all outputs 0, busy = 0; with HAZARD_PERF_EN, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: forwarding selects, load-use stalls, branch flushes.
// Define HAZARD_PERF_EN to add saturating stall/flush/forward event counters.
module hazard_ctrl #(
    parameter int LOAD_LAT  = 1,
    parameter int XLEN_REGS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [XLEN_REGS-1:0] rs1_de,
    input  logic [XLEN_REGS-1:0] rs2_de,
    input  logic [XLEN_REGS-1:0] rd_de,
    input  logic                 RUwrite_de,
    input  logic                 is_load_de,
    input  logic [XLEN_REGS-1:0] rs1_ex,
    input  logic [XLEN_REGS-1:0] rs2_ex,
    input  logic                 next_pc_src_ex,
    output logic [1:0]           fwd_a_sel,
    output logic [1:0]           fwd_b_sel,
    output logic                 stall_fe,
    output logic                 stall_de,
    output logic                 clr_de,
    output logic                 clr_ex,
    output logic                 busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt,
    output logic [31:0]          fwd_cnt
`endif
);

    // state  | meaning
    // RUN    | normal issue; single-cycle stall or flush handled in place
    // LSTALL | extra load-use stall cycles while the counter runs down
    // FLUSH  | one bubble cycle after a branch aborted a stall
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [1:0] LP_CNT_INIT = 2'(LOAD_LAT - 1);

    state_t r_state;
    state_t w_state_nxt;
    logic [1:0] r_cnt;
    logic [1:0] w_cnt_nxt;

    logic [XLEN_REGS-1:0] r_ex_rd, r_me_rd, r_wb_rd;
    logic r_ex_wr, r_me_wr, r_wb_wr;
    logic r_ex_ld, r_me_ld, r_wb_ld;

    logic w_luh;
    logic w_stall;
    logic w_clr_de;
    logic w_clr_ex;
    logic w_busy;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // A load result is not on ALU_res_me, so an ME load never sources 01.
    function automatic logic [1:0] fwd_sel(
        input logic [XLEN_REGS-1:0] rs,
        input logic [XLEN_REGS-1:0] me_rd,
        input logic                 me_wr,
        input logic                 me_ld,
        input logic [XLEN_REGS-1:0] wb_rd,
        input logic                 wb_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0) begin
            if (me_wr && !me_ld && (me_rd == rs)) begin
                sel = 2'b01;
            end else if (wb_wr && (wb_rd == rs)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(rs1_ex, r_me_rd, r_me_wr, r_me_ld, r_wb_rd, r_wb_wr);
        w_fwd_b = fwd_sel(rs2_ex, r_me_rd, r_me_wr, r_me_ld, r_wb_rd, r_wb_wr);
    end

    assign w_luh = r_ex_ld && r_ex_wr && (r_ex_rd != '0) &&
                   ((r_ex_rd == rs1_de) || (r_ex_rd == rs2_de));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (!next_pc_src_ex && w_luh) begin
                    w_cnt_nxt = LP_CNT_INIT;
                    if (LOAD_LAT > 1) begin
                        w_state_nxt = ST_LSTALL;
                    end
                end
            end
            ST_LSTALL: begin
                if (next_pc_src_ex) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = 2'd0;
                end else if (r_cnt <= 2'd1) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = 2'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 2'd1;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 2'd0;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_stall  = 1'b0;
        w_clr_de = 1'b0;
        w_clr_ex = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (next_pc_src_ex) begin
                    w_clr_de = 1'b1;
                    w_clr_ex = 1'b1;
                end else if (w_luh) begin
                    w_stall  = 1'b1;
                    w_clr_ex = 1'b1;
                end
            end
            ST_LSTALL: begin
                w_busy   = 1'b1;
                w_clr_ex = 1'b1;
                if (next_pc_src_ex) begin
                    w_clr_de = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_busy   = 1'b1;
                w_clr_de = 1'b1;
                w_clr_ex = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Outputs are held quiet while reset is asserted; a clear always beats a hold on FE/DE.
    assign fwd_a_sel = rst_n ? w_fwd_a : 2'b00;
    assign fwd_b_sel = rst_n ? w_fwd_b : 2'b00;
    assign stall_fe  = rst_n & w_stall;
    assign stall_de  = rst_n & w_stall & ~w_clr_de;
    assign clr_de    = rst_n & w_clr_de;
    assign clr_ex    = rst_n & w_clr_ex;
    assign busy      = rst_n & w_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_rd <= '0;
            r_ex_wr <= 1'b0;
            r_ex_ld <= 1'b0;
            r_me_rd <= '0;
            r_me_wr <= 1'b0;
            r_me_ld <= 1'b0;
            r_wb_rd <= '0;
            r_wb_wr <= 1'b0;
            r_wb_ld <= 1'b0;
        end else begin
            r_wb_rd <= r_me_rd;
            r_wb_wr <= r_me_wr;
            r_wb_ld <= r_me_ld;
            r_me_rd <= r_ex_rd;
            r_me_wr <= r_ex_wr;
            r_me_ld <= r_ex_ld;
            if (w_clr_ex) begin
                r_ex_rd <= '0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_rd <= rd_de;
                r_ex_wr <= RUwrite_de;
                r_ex_ld <= is_load_de;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic [31:0] r_fwd_cnt;
    logic        w_fwd_any;

    assign w_fwd_any = (fwd_a_sel != 2'b00) || (fwd_b_sel != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
            r_fwd_cnt   <= 32'd0;
        end else begin
            if (stall_fe && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (clr_de && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (w_fwd_any && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: LOAD_LAT=1 and LOAD_LAT=3 instances share stimulus and are
// compared to a pipeline-level reference model; HAZARD_PERF_EN also checks the counters.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1_de = '0, rs2_de = '0, rd_de = '0, rs1_ex = '0, rs2_ex = '0;
    logic RUwrite_de = 1'b0, is_load_de = 1'b0, next_pc_src_ex = 1'b0;

    logic [1:0][1:0] fwd_a_sel, fwd_b_sel;
    logic [1:0] stall_fe, stall_de, clr_de, clr_ex, busy;
`ifdef HAZARD_PERF_EN
    logic [1:0][31:0] stall_cnt, flush_cnt, fwd_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .XLEN_REGS(5)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
        .RUwrite_de(RUwrite_de), .is_load_de(is_load_de),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .next_pc_src_ex(next_pc_src_ex),
        .fwd_a_sel(fwd_a_sel[0]), .fwd_b_sel(fwd_b_sel[0]),
        .stall_fe(stall_fe[0]), .stall_de(stall_de[0]),
        .clr_de(clr_de[0]), .clr_ex(clr_ex[0]), .busy(busy[0])
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0]), .fwd_cnt(fwd_cnt[0])
`endif
    );

    hazard_ctrl #(.LOAD_LAT(3), .XLEN_REGS(5)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n),
        .rs1_de(rs1_de), .rs2_de(rs2_de), .rd_de(rd_de),
        .RUwrite_de(RUwrite_de), .is_load_de(is_load_de),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .next_pc_src_ex(next_pc_src_ex),
        .fwd_a_sel(fwd_a_sel[1]), .fwd_b_sel(fwd_b_sel[1]),
        .stall_fe(stall_fe[1]), .stall_de(stall_de[1]),
        .clr_de(clr_de[1]), .clr_ex(clr_ex[1]), .busy(busy[1])
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1]), .fwd_cnt(fwd_cnt[1])
`endif
    );

    // Output vector layout: {fwd_a[1:0], fwd_b[1:0], stall_fe, stall_de, clr_de, clr_ex, busy}
    localparam logic [8:0] O_IDLE       = 9'b00_00_00000;
    localparam logic [8:0] O_STALL_RUN  = 9'b00_00_11010;
    localparam logic [8:0] O_STALL_BUSY = 9'b00_00_11011;
    localparam logic [8:0] O_FLUSH_RUN  = 9'b00_00_00110;
    localparam logic [8:0] O_FLUSH_BUSY = 9'b00_00_00111;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } instr_t;

    // Reference model: the three in-flight instructions past decode, remaining extra stall
    // cycles, and whether a post-abort flush cycle is owed.
    instr_t m_ex[2], m_me[2], m_wb[2];
    int     m_left[2];
    bit     m_flush[2];
    logic [31:0] m_scnt[2], m_fcnt[2], m_wcnt[2];
    int     lat_of[2];
    logic [8:0] exp_o[2], obs_o[2];

    function automatic logic [1:0] ref_fwd(input instr_t me, input instr_t wb, input logic [4:0] rs);
        logic [1:0] r;
        r = 2'b00;
        if (rs != 5'd0) begin
            if (me.wr && !me.ld && me.rd == rs) r = 2'b01;
            else if (wb.wr && wb.rd == rs)      r = 2'b10;
        end
        return r;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ex[k] = '0; m_me[k] = '0; m_wb[k] = '0;
            m_left[k] = 0; m_flush[k] = 1'b0;
            m_scnt[k] = '0; m_fcnt[k] = '0; m_wcnt[k] = '0;
        end
    endtask

    // One pipeline cycle: drive inputs, sample and predict at negedge, advance model past posedge.
    task automatic cyc(input logic [4:0] r1d, input logic [4:0] r2d, input logic [4:0] rdd,
                       input logic wrd, input logic ldd,
                       input logic [4:0] r1e, input logic [4:0] r2e, input logic br);
        instr_t nex[2];
        int     nleft[2];
        bit     nfl[2];
        rs1_de = r1d; rs2_de = r2d; rd_de = rdd; RUwrite_de = wrd; is_load_de = ldd;
        rs1_ex = r1e; rs2_ex = r2e; next_pc_src_ex = br;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic luh, sf, cd, cx, bz;
            logic [1:0] fa, fb;
            obs_o[k] = {fwd_a_sel[k], fwd_b_sel[k], stall_fe[k], stall_de[k],
                        clr_de[k], clr_ex[k], busy[k]};
            fa = ref_fwd(m_me[k], m_wb[k], r1e);
            fb = ref_fwd(m_me[k], m_wb[k], r2e);
            luh = m_ex[k].ld && m_ex[k].wr && m_ex[k].rd != 5'd0 &&
                  (m_ex[k].rd == r1d || m_ex[k].rd == r2d);
            sf = 1'b0; cd = 1'b0; cx = 1'b0; bz = 1'b0;
            nleft[k] = 0; nfl[k] = 1'b0;
            if (m_flush[k]) begin
                cd = 1'b1; cx = 1'b1; bz = 1'b1;
            end else if (m_left[k] > 0) begin
                bz = 1'b1; cx = 1'b1;
                if (br) begin
                    cd = 1'b1; nfl[k] = 1'b1;
                end else begin
                    sf = 1'b1; nleft[k] = m_left[k] - 1;
                end
            end else if (br) begin
                cd = 1'b1; cx = 1'b1;
            end else if (luh) begin
                sf = 1'b1; cx = 1'b1; nleft[k] = lat_of[k] - 1;
            end
            if (!rst_n) exp_o[k] = '0;
            else        exp_o[k] = {fa, fb, sf, sf, cd, cx, bz};
            if (cx) nex[k] = '0;
            else begin
                nex[k].rd = rdd; nex[k].wr = wrd; nex[k].ld = ldd;
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else begin
            for (int k = 0; k < 2; k++) begin
                m_wb[k] = m_me[k]; m_me[k] = m_ex[k]; m_ex[k] = nex[k];
                m_left[k] = nleft[k]; m_flush[k] = nfl[k];
                m_scnt[k] = sat_inc(m_scnt[k], exp_o[k][4]);
                m_fcnt[k] = sat_inc(m_fcnt[k], exp_o[k][2]);
                m_wcnt[k] = sat_inc(m_wcnt[k], exp_o[k][8:5] != 4'd0);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(5'd6, 5'd6, 5'd3, 1, 1, 5'd6, 5'd6, 1);
        cyc(5'd6, 5'd6, 5'd3, 1, 1, 5'd6, 5'd6, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== O_IDLE) begin
                errors++; $display("FAIL reset_out dut%0d: got %b want %b", k, obs_o[k], O_IDLE);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if ({stall_cnt[k], flush_cnt[k], fwd_cnt[k]} !== 96'd0) begin
                errors++; $display("FAIL reset_cnt dut%0d: got %h %h %h want 0", k, stall_cnt[k], flush_cnt[k], fwd_cnt[k]);
            end
`endif
        end
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== O_IDLE) begin
                errors++; $display("FAIL post_reset dut%0d: got %b want %b", k, obs_o[k], O_IDLE);
            end
        end
    endtask

    task automatic test_forward();
        idle(3);
        cyc(1, 2, 5, 1, 0, 0, 0, 0);          // add x5
        cyc(5, 0, 7, 1, 0, 1, 2, 0);          // sub x7, x5
        cyc(5, 5, 8, 1, 0, 5, 0, 0);          // sub in EX reads x5 from ME
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== 9'b01_00_00000) begin
                errors++; $display("FAIL fwd_me dut%0d: got %b want %b", k, obs_o[k], 9'b01_00_00000);
            end
        end
        cyc(0, 0, 0, 0, 0, 5, 5, 0);          // next reads x5 from WB
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== 9'b10_10_00000) begin
                errors++; $display("FAIL fwd_wb dut%0d: got %b want %b", k, obs_o[k], 9'b10_10_00000);
            end
        end
    endtask

    task automatic test_load_use();
        idle(3);
        cyc(0, 0, 6, 1, 1, 0, 0, 0);          // lw x6
        cyc(1, 6, 9, 1, 0, 0, 0, 0);          // add x9, x1, x6
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== O_STALL_RUN) begin
                errors++; $display("FAIL luh_first dut%0d: got %b want %b", k, obs_o[k], O_STALL_RUN);
            end
        end
        cyc(1, 6, 9, 1, 0, 0, 0, 0);
        checks++;
        if (obs_o[0] !== O_IDLE) begin
            errors++; $display("FAIL luh_l1_done: got %b want %b", obs_o[0], O_IDLE);
        end
        checks++;
        if (obs_o[1] !== O_STALL_BUSY) begin
            errors++; $display("FAIL luh_l3_c2: got %b want %b", obs_o[1], O_STALL_BUSY);
        end
        cyc(3, 0, 10, 1, 0, 1, 6, 0);
        checks++;
        if (obs_o[0] !== 9'b00_10_00000) begin
            errors++; $display("FAIL luh_l1_fwd: got %b want %b", obs_o[0], 9'b00_10_00000);
        end
        checks++;
        if (obs_o[1] !== 9'b00_10_11011) begin
            errors++; $display("FAIL luh_l3_c3: got %b want %b", obs_o[1], 9'b00_10_11011);
        end
        idle(1);
        checks++;
        if (obs_o[1] !== O_IDLE) begin
            errors++; $display("FAIL luh_l3_end: got %b want %b", obs_o[1], O_IDLE);
        end
    endtask

    task automatic test_stall_abort();
        idle(3);
        cyc(0, 0, 6, 1, 1, 0, 0, 0);
        cyc(1, 6, 9, 1, 0, 0, 0, 0);
        cyc(1, 6, 9, 1, 0, 0, 0, 1);          // branch in the first LSTALL cycle
        checks++;
        if (obs_o[1] !== O_FLUSH_BUSY) begin
            errors++; $display("FAIL abort_c2: got %b want %b", obs_o[1], O_FLUSH_BUSY);
        end
        checks++;
        if (obs_o[0] !== O_FLUSH_RUN) begin
            errors++; $display("FAIL abort_l1: got %b want %b", obs_o[0], O_FLUSH_RUN);
        end
        idle(1);
        checks++;
        if (obs_o[1] !== O_FLUSH_BUSY) begin
            errors++; $display("FAIL abort_flush: got %b want %b", obs_o[1], O_FLUSH_BUSY);
        end
        idle(1);
        checks++;
        if (obs_o[1] !== O_IDLE) begin
            errors++; $display("FAIL abort_run: got %b want %b", obs_o[1], O_IDLE);
        end
    endtask

    task automatic test_branch_over_luh();
        idle(3);
        cyc(0, 0, 6, 1, 1, 0, 0, 0);
        cyc(6, 0, 9, 1, 0, 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== O_FLUSH_RUN) begin
                errors++; $display("FAIL br_luh dut%0d: got %b want %b", k, obs_o[k], O_FLUSH_RUN);
            end
        end
    endtask

    task automatic test_x0();
        idle(3);
        cyc(0, 0, 0, 1, 1, 0, 0, 0);          // lw x0
        cyc(0, 0, 0, 1, 0, 0, 0, 0);          // add x0 reading x0
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== O_IDLE) begin
                errors++; $display("FAIL x0 dut%0d: got %b want %b", k, obs_o[k], O_IDLE);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        cyc(0, 0, 6, 1, 1, 0, 0, 0);
        cyc(1, 6, 9, 1, 0, 0, 0, 0);
        cyc(1, 6, 9, 1, 0, 0, 0, 0);
        checks++;
        if (obs_o[1] !== O_STALL_BUSY) begin
            errors++; $display("FAIL mid_pre: got %b want %b", obs_o[1], O_STALL_BUSY);
        end
        rst_n = 1'b0;
        cyc(1, 6, 9, 1, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_o[k] !== O_IDLE) begin
                errors++; $display("FAIL mid_rst dut%0d: got %b want %b", k, obs_o[k], O_IDLE);
            end
`ifdef HAZARD_PERF_EN
            checks++;
            if ({stall_cnt[k], flush_cnt[k], fwd_cnt[k]} !== 96'd0) begin
                errors++; $display("FAIL mid_rst_cnt dut%0d: got %h %h %h want 0", k, stall_cnt[k], flush_cnt[k], fwd_cnt[k]);
            end
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            cyc(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 7) == 0));
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_o[k] !== exp_o[k]) begin
                    errors++; $display("FAIL rand_out dut%0d cyc %0d: got %b want %b", k, i, obs_o[k], exp_o[k]);
                end
`ifdef HAZARD_PERF_EN
                checks++;
                if ({stall_cnt[k], flush_cnt[k], fwd_cnt[k]} !== {m_scnt[k], m_fcnt[k], m_wcnt[k]}) begin
                    errors++; $display("FAIL rand_cnt dut%0d cyc %0d: got %0d %0d %0d want %0d %0d %0d", k, i,
                                       stall_cnt[k], flush_cnt[k], fwd_cnt[k], m_scnt[k], m_fcnt[k], m_wcnt[k]);
                end
`endif
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        lat_of[0] = 1;
        lat_of[1] = 3;
        model_reset();
        test_reset();
        test_forward();
        test_load_use();
        test_stall_abort();
        test_branch_over_luh();
        test_x0();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
